if_fetch_queue: RTL and testbench

- Fetch stage between the PC register and the ID stage.
- Issues instruction-memory reads for the current PC and tells the PC register when to advance.
- Buffers returned instructions in order in a small queue and drives the IF/ID pipeline register.
- Supports variable-latency instruction memory, ID/cache stalls, and branch flushes. Wrong-path responses are discarded.

---
 rtl/if_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/if_fetch_queue.sv | 91 +++++++++
 tb/tb_if_fetch_queue.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
    logic                    filled;
  } entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order fetch buffer: entries are allocated at issue, filled by memory
// responses in request order, and popped into IF/ID once filled.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            clear_i,
  input  logic            alloc_i,
  input  logic [XLEN-1:0] alloc_pc_i,
  input  logic            fill_i,
  input  logic [XLEN-1:0] fill_data_i,
  input  logic            pop_i,
  output logic [CW-1:0]   alloc_cnt_o,
  output logic [CW-1:0]   unfilled_cnt_o,
  output logic            head_filled_o,
  output logic [XLEN-1:0] head_pc_o,
  output logic [XLEN-1:0] head_instr_o
);

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [PW-1:0]   tail, fill_ptr, head;
  logic [CW-1:0]   alloc_cnt, filled_cnt;

  // NOTE: the storage arrays carry no reset; the counters alone define which
  // entries are live, so stale data is never observed and the RAM stays cheap.
  always_ff @(posedge clk_i) begin
    if (alloc_i) pc_mem[tail]        <= alloc_pc_i;
    if (fill_i)  instr_mem[fill_ptr] <= fill_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tail       <= '0;
      fill_ptr   <= '0;
      head       <= '0;
      alloc_cnt  <= '0;
      filled_cnt <= '0;
    end else if (clear_i) begin
      tail       <= '0;
      fill_ptr   <= '0;
      head       <= '0;
      alloc_cnt  <= '0;
      filled_cnt <= '0;
    end else begin
      if (alloc_i) tail     <= tail + PW'(1);
      if (fill_i)  fill_ptr <= fill_ptr + PW'(1);
      if (pop_i)   head     <= head + PW'(1);
      alloc_cnt  <= alloc_cnt + CW'(alloc_i) - CW'(pop_i);
      filled_cnt <= filled_cnt + CW'(fill_i) - CW'(pop_i);
    end
  end

  // Fills land in order from the head, so filled entries always form a prefix.
  assign alloc_cnt_o    = alloc_cnt;
  assign unfilled_cnt_o = alloc_cnt - filled_cnt;
  assign head_filled_o  = (filled_cnt != '0);
  assign head_pc_o      = pc_mem[head];
  assign head_instr_o   = instr_mem[head];

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage: issues imem reads for the PC, buffers responses in order,
// discards wrong-path responses after a flush, and drives IF/ID.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_advance_o,
  input  logic            flush_i,
  input  logic            stall_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            ifid_valid_o,
  output logic [XLEN-1:0] ifid_pc_o,
  output logic [XLEN-1:0] ifid_instr_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]   alloc_cnt, unfilled_cnt, drop_cnt;
  logic            head_filled, room, accept, fill, pop;
  logic [XLEN-1:0] head_pc, head_instr;

  // Responses still owed to flushed requests occupy slots until they drain.
  assign room         = ({1'b0, alloc_cnt} + {1'b0, drop_cnt}) < (CW+1)'(DEPTH);
  assign imem_req_o   = start_i & ~flush_i & room;
  assign imem_addr_o  = pc_i;
  assign accept       = imem_req_o & imem_ack_i;
  assign pc_advance_o = accept;
  assign fill         = imem_rvalid_i & ~flush_i & (drop_cnt == '0);
  assign pop          = ~flush_i & ~stall_i & head_filled;

  fetch_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fifo (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .clear_i        (flush_i),
    .alloc_i        (accept),
    .alloc_pc_i     (pc_i),
    .fill_i         (fill),
    .fill_data_i    (imem_rdata_i),
    .pop_i          (pop),
    .alloc_cnt_o    (alloc_cnt),
    .unfilled_cnt_o (unfilled_cnt),
    .head_filled_o  (head_filled),
    .head_pc_o      (head_pc),
    .head_instr_o   (head_instr)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      drop_cnt <= '0;
    end else if (flush_i) begin
      // Every in-flight request becomes wrong-path; one may be answered right now.
      drop_cnt <= unfilled_cnt + drop_cnt - CW'(imem_rvalid_i);
    end else if (imem_rvalid_i && drop_cnt != '0) begin
      drop_cnt <= drop_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ifid_valid_o <= 1'b0;
      ifid_pc_o    <= '0;
      ifid_instr_o <= XLEN'(NOP_INSTR);
    end else if (flush_i) begin
      ifid_valid_o <= 1'b0;
      ifid_instr_o <= XLEN'(NOP_INSTR);
    end else if (!stall_i) begin
      if (head_filled) begin
        ifid_valid_o <= 1'b1;
        ifid_pc_o    <= head_pc;
        ifid_instr_o <= head_instr;
      end else begin
        ifid_valid_o <= 1'b0;
        ifid_instr_o <= XLEN'(NOP_INSTR);
      end
    end
  end

  a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    imem_rvalid_i |-> (unfilled_cnt != '0 || drop_cnt != '0));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue: a PC register and memory model drive the
// DUT, accepted fetches are scoreboarded and compared as they reach IF/ID.
module tb_if_fetch_queue;
  import if_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0, rst_n_i = 1'b0, start_i = 1'b0;
  logic        flush_i = 1'b0, stall_i = 1'b0;
  logic        imem_ack_i = 1'b0, imem_rvalid_i = 1'b0;
  logic [31:0] pc_i = '0, imem_rdata_i = '0;
  logic        pc_advance_o, imem_req_o, ifid_valid_o;
  logic [31:0] imem_addr_o, ifid_pc_o, ifid_instr_o;

  always #5 clk_i = ~clk_i;

  if_fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .pc_i(pc_i),
    .pc_advance_o(pc_advance_o), .flush_i(flush_i), .stall_i(stall_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .ifid_valid_o(ifid_valid_o), .ifid_pc_o(ifid_pc_o), .ifid_instr_o(ifid_instr_o)
  );

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: a fixed function of the address, never equal to a NOP.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'hC3A5_0000;
  endfunction

  typedef struct { logic [31:0] addr; int cyc; bit stale; } pend_t;

  entry_t exp_q[$];   // accepted fetches not yet delivered to IF/ID
  pend_t  pend[$];    // requests the memory still owes a response for

  int          ack_mode = 0;   // 0 always, 1 never, 2 random
  int          resp_mode = 0;  // 0 as soon as legal, 1 hold, 2 random
  bit          k_start = 0, k_stall = 0, k_flush = 0;
  logic [31:0] flush_target = '0;
  int          cyc_no = 0, n_acc = 0;
  bit          last_stall = 0, last_flush = 0, mon_en = 0;

  function automatic int stale_count();
    int n = 0;
    foreach (pend[i]) if (pend[i].stale) n++;
    return n;
  endfunction

  // One clock: drive at negedge, check issue side, update the PC model after the edge.
  task automatic cycle();
    int stale_pre, stale_post;
    bit exp_req, acc;
    @(negedge clk_i);
    stale_pre = stale_count();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if (pend.size() > 0 && pend[0].cyc < cyc_no &&
        (resp_mode == 0 || (resp_mode == 2 && $urandom_range(0, 2) != 0))) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = instr_of(pend[0].addr);
      void'(pend.pop_front());
    end
    imem_ack_i = (ack_mode == 0) ? 1'b1 : (ack_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    start_i = k_start;
    stall_i = k_stall;
    flush_i = k_flush;
    #1;
    exp_req = k_start && !k_flush && (exp_q.size() + stale_pre < DEPTH);
    acc = exp_req && imem_ack_i;
    check("imem_req", 32'(imem_req_o), 32'(exp_req));
    check("pc_advance", 32'(pc_advance_o), 32'(acc));
    if (imem_req_o) check("imem_addr", imem_addr_o, pc_i);
    if (k_flush) begin
      exp_q.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
    end
    if (acc) begin
      exp_q.push_back('{pc: pc_i, instr: instr_of(pc_i), filled: 1'b1});
      pend.push_back('{addr: pc_i, cyc: cyc_no, stale: 1'b0});
      n_acc++;
    end
    last_stall = k_stall;
    last_flush = k_flush;
    mon_en = 1'b1;
    @(posedge clk_i);
    #1;
    cyc_no++;
    if (k_flush) pc_i = flush_target;
    else if (acc) pc_i = pc_i + 32'd4;
    stale_post = stale_count();
    check("drop_cnt", 32'(dut.drop_cnt), 32'(stale_post));
  endtask

  task automatic drain();
    int n = 0;
    k_start = 0; k_stall = 0; k_flush = 0; resp_mode = 0;
    while ((exp_q.size() > 0 || pend.size() > 0 || ifid_valid_o) && n < 50) begin
      cycle();
      n++;
    end
    check("drain_bound", 32'(n < 50), 32'd1);
  endtask

  // Monitor: every IF/ID update is compared against the scoreboard.
  initial begin
    logic        pv;
    logic [31:0] ppc, pin;
    entry_t      e;
    pv = 1'b0; ppc = '0; pin = NOP;
    forever begin
      @(posedge clk_i);
      #2;
      if (mon_en && rst_n_i) begin
        if (last_flush) begin
          check("flush_valid", 32'(ifid_valid_o), 32'd0);
          check("flush_instr", ifid_instr_o, NOP);
        end else if (last_stall) begin
          check("stall_hold_valid", 32'(ifid_valid_o), 32'(pv));
          check("stall_hold_pc", ifid_pc_o, ppc);
          check("stall_hold_instr", ifid_instr_o, pin);
        end else if (ifid_valid_o) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ifid_unexpected: got pc %h with no fetch outstanding", ifid_pc_o);
          end else begin
            e = exp_q.pop_front();
            check("ifid_pc", ifid_pc_o, e.pc);
            check("ifid_instr", ifid_instr_o, e.instr);
          end
        end else begin
          check("bubble_instr", ifid_instr_o, NOP);
          check("bubble_pc_hold", ifid_pc_o, ppc);
        end
      end
      pv = ifid_valid_o; ppc = ifid_pc_o; pin = ifid_instr_o;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n;
    logic [31:0] held_addr;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", 32'(ifid_valid_o), 32'd0);
    check("rst_pc", ifid_pc_o, 32'd0);
    check("rst_instr", ifid_instr_o, NOP);
    check("rst_req", 32'(imem_req_o), 32'd0);
    @(posedge clk_i);
    #3;
    rst_n_i = 1'b1;

    // Zero-wait memory: one fetch per cycle, IF/ID follows two cycles later
    k_start = 1; ack_mode = 0; resp_mode = 0;
    n0 = n_acc;
    for (int i = 0; i < 21; i++) begin
      cycle();
      if (i >= 2) begin
        check("zw_valid", 32'(ifid_valid_o), 32'd1);
        check("zw_pc", ifid_pc_o, 32'(4 * (i - 2)));
      end
    end
    check("zw_accepts", 32'(n_acc - n0), 32'd21);

    // Memory backpressure: request held with a steady address
    ack_mode = 1;
    held_addr = pc_i;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("bp_req", 32'(imem_req_o), 32'd1);
      check("bp_addr", imem_addr_o, held_addr);
    end
    check("bp_bubble_valid", 32'(ifid_valid_o), 32'd0);
    check("bp_bubble_instr", ifid_instr_o, NOP);

    // Full queue under a long stall
    drain();
    k_start = 1; k_stall = 1; ack_mode = 0; resp_mode = 0;
    n0 = n_acc;
    repeat (8) cycle();
    check("full_accepts", 32'(n_acc - n0), 32'(DEPTH));
    check("full_req_low", 32'(imem_req_o), 32'd0);
    k_stall = 0;
    repeat (8) cycle();

    // Flush with two responses in flight
    drain();
    k_start = 1; resp_mode = 1; ack_mode = 0;
    n0 = n_acc;
    cycle();
    cycle();
    check("fl_inflight", 32'(n_acc - n0), 32'd2);
    k_flush = 1; flush_target = 32'h40;
    cycle();
    k_flush = 0;
    check("fl_valid", 32'(ifid_valid_o), 32'd0);
    check("fl_drop_cnt", 32'(dut.drop_cnt), 32'd2);
    resp_mode = 0;
    n = 0;
    while (!ifid_valid_o && n < 20) begin
      cycle();
      n++;
    end
    check("fl_first_seen", 32'(ifid_valid_o), 32'd1);
    check("fl_first_pc", ifid_pc_o, 32'h40);

    // Flush and stall together: flush wins
    repeat (3) cycle();
    k_flush = 1; k_stall = 1; flush_target = 32'h100;
    cycle();
    k_flush = 0; k_stall = 0;
    check("fs_valid", 32'(ifid_valid_o), 32'd0);
    check("fs_instr", ifid_instr_o, NOP);
    repeat (10) cycle();

    // Randomized traffic
    ack_mode = 2; resp_mode = 2;
    repeat (1500) begin
      k_start = ($urandom_range(0, 9) != 0);
      k_stall = ($urandom_range(0, 3) == 0);
      k_flush = ($urandom_range(0, 19) == 0);
      flush_target = 32'($urandom_range(0, 1023)) << 2;
      cycle();
    end
    k_flush = 0; k_stall = 0;
    drain();

    // Asynchronous reset in the middle of a stream
    k_start = 1; ack_mode = 0; resp_mode = 0;
    repeat (6) cycle();
    @(negedge clk_i);
    #2;
    mon_en = 0;
    rst_n_i = 1'b0;
    #1;
    check("arst_valid", 32'(ifid_valid_o), 32'd0);
    check("arst_pc", ifid_pc_o, 32'd0);
    check("arst_instr", ifid_instr_o, NOP);
    check("arst_drop", 32'(dut.drop_cnt), 32'd0);
    exp_q.delete();
    pend.delete();
    pc_i = '0;
    imem_rvalid_i = 1'b0;
    imem_ack_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #3;
    rst_n_i = 1'b1;
    n = 0;
    while (!ifid_valid_o && n < 20) begin
      cycle();
      n++;
    end
    check("arst_restart_seen", 32'(ifid_valid_o), 32'd1);
    check("arst_restart_pc", ifid_pc_o, 32'd0);
    repeat (5) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
